// File: rtl/audio_pkg.sv
// Shared audio types and frame constants.
// Stereo sample struct plus I2S slot counts.
package audio_pkg;
  localparam int SAMPLE_WIDTH     = 16;
  localparam int SLOTS_PER_FRAME  = 32;
  localparam int HALF_FRAME_SLOTS = 16;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;
endpackage

// File: rtl/i2s_dac_tx_if.sv
// Stereo sample valid/ready handshake.
// master: drives sample_l/r, sample_valid; slave: drives sample_ready.
interface i2s_dac_tx_if;
  import audio_pkg::*;

  sample_t sample_l;
  sample_t sample_r;
  logic    sample_valid;
  logic    sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit clock divider from MCLK.
// Ports: clock, reset in; bclk (registered), fall (last MCLK of BCLK period) out.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clock,
  input  logic reset,
  output logic bclk,
  output logic fall
);
  localparam int CW = $clog2(BCLK_DIV);

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_nxt;

  assign fall = (div_cnt == CW'(BCLK_DIV - 1));

  always_comb begin
    div_nxt = div_cnt + 1'b1;
    if (fall) div_nxt = '0;
  end

  // bclk is computed from the next count so it tracks div_cnt exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bclk    <= (div_nxt >= CW'(BCLK_DIV / 2));
    end
  end
endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the SSM2603 DAC path.
// Ports: clock, reset, snk (sample handshake), clear_underrun in;
// bclk, lrclk, dac_data, frame_strobe, underrun out.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV     = 8,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  i2s_dac_tx_if.slave  snk,
  input  logic         clear_underrun,
  output logic         bclk,
  output logic         lrclk,
  output logic         dac_data,
  output logic         frame_strobe,
  output logic         underrun
);
  localparam int FW = 2 * SAMPLE_WIDTH;

  logic          fall;
  logic          load;
  logic          accept;
  logic          full;
  logic [4:0]    slot;
  logic [4:0]    slot_nxt;
  stereo_t       hold;
  logic [FW-1:0] shifter;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk (
    .clock (clock),
    .reset (reset),
    .bclk  (bclk),
    .fall  (fall)
  );

  assign load             = fall && (slot == '0);
  assign accept           = snk.sample_valid && !full;
  assign snk.sample_ready = !full;
  // MSB of the shifter is the line; loads and shifts happen only on fall.
  assign dac_data         = shifter[FW-1];

  always_comb begin
    slot_nxt = slot + 1'b1;
    if (slot == 5'(SLOTS_PER_FRAME - 1)) slot_nxt = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot         <= '0;
      lrclk        <= 1'b0;
      frame_strobe <= 1'b0;
      shifter      <= '0;
      hold         <= '0;
      full         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_strobe <= load;
      if (fall) begin
        slot  <= slot_nxt;
        lrclk <= (slot_nxt >= 5'(HALF_FRAME_SLOTS));
      end
      if (load) shifter <= hold;
      else if (fall) shifter <= {shifter[FW-2:0], 1'b0};
      // A capture in the load cycle refills the buffer; no bypass.
      if (accept) begin
        hold <= {snk.sample_l, snk.sample_r};
        full <= 1'b1;
      end else if (load) begin
        full <= 1'b0;
      end
      if (load && !full) underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx with BCLK_DIV=8.
// n = MCLK edges since reset release; outputs sampled 1ns after edges.
module tb_i2s_dac_tx;
  logic clock = 1'b0;
  logic reset;
  logic clear_underrun;
  logic bclk, lrclk, dac_data, frame_strobe, underrun;
  int   checks = 0;
  int   failures = 0;
  int   n = 0;

  i2s_dac_tx_if bus ();

  i2s_dac_tx #(
    .BCLK_DIV (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .snk            (bus),
    .clear_underrun (clear_underrun),
    .bclk           (bclk),
    .lrclk          (lrclk),
    .dac_data       (dac_data),
    .frame_strobe   (frame_strobe),
    .underrun       (underrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    clear_underrun = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n = 0;
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    bus.sample_l = l;
    bus.sample_r = r;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic grab(input int base, output logic [31:0] got);
    for (int s = 1; s <= 32; s++) begin
      run_to(base + 8 * s + 4);
      got[32-s] = dac_data;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_l = '0;
    bus.sample_r = '0;
    clear_underrun = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({bclk, lrclk, dac_data, frame_strobe, underrun,
         bus.sample_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_state got=%b exp=000001",
               {bclk, lrclk, dac_data, frame_strobe, underrun,
                bus.sample_ready});
    end
  endtask

  // Idle run from release: no samples, so data stays 0.
  task automatic test_timing(input string tag);
    logic [4:0] exp, got;
    for (int i = 0; i <= 300; i++) begin
      exp = {((n % 8) >= 4), (((n / 8) % 32) >= 16),
             (n % 256 == 8), 1'b0, (n >= 8)};
      got = {bclk, lrclk, frame_strobe, dac_data, underrun};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s n=%0d b/lr/fs/d/u got=%b exp=%b",
                 tag, n, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_serial();
    logic [31:0] got;
    do_reset();
    offer(16'hA55A, 16'h0F0F);
    checks++;
    if (bus.sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL ser_ready_full got=%b exp=0", bus.sample_ready);
    end
    run_to(8);
    checks++;
    if ({bus.sample_ready, frame_strobe} !== 2'b11) begin
      failures++;
      $display("FAIL ser_after_load got=%b exp=11",
               {bus.sample_ready, frame_strobe});
    end
    grab(0, got);
    checks++;
    if (got !== 32'hA55A0F0F) begin
      failures++;
      $display("FAIL ser_bits got=%h exp=a55a0f0f", got);
    end
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL ser_underrun got=%b exp=0", underrun);
    end
  endtask

  task automatic test_continuous();
    logic exp;
    do_reset();
    bus.sample_l = 16'h1111;
    bus.sample_r = 16'h2222;
    bus.sample_valid = 1'b1;
    for (int i = 0; i <= 530; i++) begin
      exp = (n == 0) || (n % 256 == 8);
      checks++;
      if (bus.sample_ready !== exp) begin
        failures++;
        $display("FAIL cont_ready n=%0d got=%b exp=%b",
                 n, bus.sample_ready, exp);
      end
      tick();
    end
    bus.sample_valid = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL cont_underrun got=%b exp=0", underrun);
    end
  endtask

  task automatic test_late_offer();
    logic [31:0] got;
    do_reset();
    offer(16'hA55A, 16'h0F0F);
    run_to(263);
    bus.sample_l = 16'h1234;
    bus.sample_r = 16'h8001;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    checks++;
    if ({underrun, bus.sample_ready, frame_strobe} !== 3'b101) begin
      failures++;
      $display("FAIL late_flags u/rdy/fs got=%b exp=101",
               {underrun, bus.sample_ready, frame_strobe});
    end
    grab(256, got);
    checks++;
    if (got !== 32'hA55A0F0F) begin
      failures++;
      $display("FAIL late_replay got=%h exp=a55a0f0f", got);
    end
    grab(512, got);
    checks++;
    if (got !== 32'h12348001) begin
      failures++;
      $display("FAIL late_next got=%h exp=12348001", got);
    end
  endtask

  task automatic test_clear();
    do_reset();
    run_to(7);
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL clr_set_wins got=%b exp=1", underrun);
    end
    run_to(20);
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL clr_alone got=%b exp=0", underrun);
    end
    run_to(263);
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL clr_hold got=%b exp=0", underrun);
    end
    tick();
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL clr_reset got=%b exp=1", underrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    offer(16'hFFFF, 16'hFFFF);
    run_to(100);
    offer(16'h1234, 16'h5678);
    run_to(166);
    checks++;
    if ({bclk, lrclk, dac_data, bus.sample_ready} !== 4'b1110) begin
      failures++;
      $display("FAIL mid_pre b/lr/d/rdy got=%b exp=1110",
               {bclk, lrclk, dac_data, bus.sample_ready});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bclk, lrclk, dac_data, bus.sample_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL mid_async b/lr/d/rdy got=%b exp=0001",
               {bclk, lrclk, dac_data, bus.sample_ready});
    end
    do_reset();
    test_timing("post_rst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    do_reset();
    test_timing("idle");
    test_serial();
    test_continuous();
    test_late_offer();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
